udm_uart_rx_fifo: RTL and testbench

Parametrised UART receiver for the UDM debug path: the next generation of the fixed 8N1 receive path driven by the UDM bench drivers. Adds runtime baud divider, parity mode and stop-bit count, start-bit glitch rejection, error reporting, and a receive FIFO with a valid/ready output. Sits between the board UART_TXD_IN pin (after the top-level wrapper) and the UDM command decoder.

---
 rtl/udm_uart_pkg.sv | 23 ++
 rtl/udm_sync_fifo.sv | 66 ++++++
 rtl/udm_uart_rx_fifo.sv | 191 +++++++++++++++++++
 tb/tb_udm_uart_rx_fifo.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/udm_uart_pkg.sv
// Shared types and constants for the UDM UART receive path.
package udm_uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10,
        PAR_RSVD = 2'b11
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_HIGH
    } rx_state_e;

    // Smallest bit period the sampler can resolve; smaller divider values are clamped up
    localparam int unsigned MIN_DIV = 4;

endpackage

// File: rtl/udm_sync_fifo.sv
// Synchronous FIFO with a registered head word and registered empty flag.
// A pop on a full FIFO frees a slot for a same-cycle push; a push into an
// empty FIFO becomes visible on the next cycle (no fall-through).
module udm_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             full_o,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr_q;
    logic [PW-1:0]    rptr_q;
    logic [PW-1:0]    wptr_n;
    logic [PW-1:0]    rptr_n;
    logic             push_eff;
    logic             pop_eff;
    logic [WIDTH-1:0] head_n;

    assign full_o   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop_eff  = pop_i && !empty_o;
    assign push_eff = push_i && (!full_o || pop_eff);
    assign wptr_n   = wptr_q + PW'(push_eff);
    assign rptr_n   = rptr_q + PW'(pop_eff);

    // Next head word: the incoming word when it lands in the head slot, else storage
    always_comb begin
        head_n = rdata_o;
        if (wptr_n != rptr_n) begin
            head_n = (rptr_n == wptr_q) ? wdata_i : mem[rptr_n[AW-1:0]];
        end
    end

    // Storage array write port
    always_ff @(posedge clk_i) begin
        if (push_eff) begin
            mem[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

    // Pointers, registered head and empty flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            rdata_o <= '0;
            empty_o <= 1'b1;
        end else begin
            wptr_q  <= wptr_n;
            rptr_q  <= rptr_n;
            rdata_o <= head_n;
            empty_o <= (wptr_n == rptr_n);
        end
    end

endmodule

// File: rtl/udm_uart_rx_fifo.sv
// UART receiver for the UDM debug path: runtime divider, parity and stop-bit
// count, start-bit glitch rejection, error pulses and a receive FIFO.
module udm_uart_rx_fifo
    import udm_uart_pkg::*;
#(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned DIV_W       = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 rx_i,
    input  logic [DIV_W-1:0]     cfg_div_i,
    input  logic [1:0]           cfg_parity_i,
    input  logic                 cfg_stop2_i,
    output logic [DATA_BITS-1:0] rdata_o,
    output logic                 rvalid_o,
    input  logic                 rready_i,
    output logic                 frame_err_o,
    output logic                 parity_err_o,
    output logic                 overflow_o,
    output logic                 busy_o
);

    localparam int unsigned BIT_W = $clog2(DATA_BITS);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;

    rx_state_e              state_q;
    logic [DIV_W-1:0]       cnt_q;
    logic [DIV_W-1:0]       div_q;
    logic [DIV_W-1:0]       div_lat;
    logic [DIV_W-1:0]       half;
    parity_e                par_q;
    logic                   stop2_q;
    logic                   stop_idx_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic [BIT_W-1:0]       bit_idx_q;
    logic                   par_bad_q;
    logic                   frame_bad_q;
    logic                   frame_bad_n;
    logic                   par_en;
    logic                   par_calc;
    logic                   sample;
    logic                   cnt_last;
    logic                   push_q;
    logic                   fifo_full;
    logic                   fifo_empty;

    // Bring the asynchronous line into the clock domain; idles high through reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
        end
    end

    assign rx_s        = sync_q[SYNC_STAGES-1];
    assign div_lat     = (cfg_div_i < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : cfg_div_i;
    assign half        = div_q >> 1;
    assign sample      = (cnt_q == half);
    assign cnt_last    = (cnt_q == div_q - DIV_W'(1));
    assign par_en      = (par_q == PAR_EVEN) || (par_q == PAR_ODD);
    assign par_calc    = ^{shift_q, rx_s};
    assign frame_bad_n = frame_bad_q | ~rx_s;

    // Frame FSM; the start-detect cycle is bit-timer count 0, so the timer loads 1
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            div_q        <= DIV_W'(MIN_DIV);
            par_q        <= PAR_NONE;
            stop2_q      <= 1'b0;
            stop_idx_q   <= 1'b0;
            shift_q      <= '0;
            bit_idx_q    <= '0;
            par_bad_q    <= 1'b0;
            frame_bad_q  <= 1'b0;
            push_q       <= 1'b0;
            frame_err_o  <= 1'b0;
            parity_err_o <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            push_q       <= 1'b0;
            frame_err_o  <= 1'b0;
            parity_err_o <= 1'b0;
            if (state_q != ST_IDLE) begin
                cnt_q <= cnt_last ? '0 : cnt_q + DIV_W'(1);
            end
            case (state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_q     <= ST_START;
                        busy_o      <= 1'b1;
                        cnt_q       <= DIV_W'(1);
                        div_q       <= div_lat;
                        par_q       <= parity_e'(cfg_parity_i);
                        stop2_q     <= cfg_stop2_i;
                        stop_idx_q  <= 1'b0;
                        bit_idx_q   <= '0;
                        par_bad_q   <= 1'b0;
                        frame_bad_q <= 1'b0;
                    end
                end
                ST_START: begin
                    if (sample) begin
                        if (rx_s) begin
                            state_q <= ST_IDLE;
                            busy_o  <= 1'b0;
                        end else begin
                            state_q <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (sample) begin
                        shift_q   <= {rx_s, shift_q[DATA_BITS-1:1]};
                        bit_idx_q <= bit_idx_q + BIT_W'(1);
                        if (bit_idx_q == BIT_W'(DATA_BITS - 1)) begin
                            state_q <= par_en ? ST_PARITY : ST_STOP;
                        end
                    end
                end
                ST_PARITY: begin
                    if (sample) begin
                        par_bad_q <= (par_calc != (par_q == PAR_ODD));
                        state_q   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (sample) begin
                        frame_bad_q <= frame_bad_n;
                        if (stop2_q && !stop_idx_q) begin
                            stop_idx_q <= 1'b1;
                        end else begin
                            parity_err_o <= par_bad_q;
                            frame_err_o  <= frame_bad_n;
                            push_q       <= !par_bad_q && !frame_bad_n;
                            if (frame_bad_n) begin
                                state_q <= ST_WAIT_HIGH;
                            end else begin
                                state_q <= ST_IDLE;
                                busy_o  <= 1'b0;
                            end
                        end
                    end
                end
                ST_WAIT_HIGH: begin
                    if (rx_s) begin
                        state_q <= ST_IDLE;
                        busy_o  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

    // Flag a good byte that found the FIFO full with no pop freeing a slot
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_o <= 1'b0;
        end else begin
            overflow_o <= push_q && fifo_full && !(rready_i && !fifo_empty);
        end
    end

    udm_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push_q),
        .wdata_i (shift_q),
        .full_o  (fifo_full),
        .pop_i   (rready_i),
        .rdata_o (rdata_o),
        .empty_o (fifo_empty)
    );

    assign rvalid_o = !fifo_empty;

endmodule

// File: tb/tb_udm_uart_rx_fifo.sv
// Directed bench for udm_uart_rx_fifo with a byte scoreboard and pulse counters.
module tb_udm_uart_rx_fifo;

    localparam int unsigned DATA_BITS   = 8;
    localparam int unsigned FIFO_DEPTH  = 16;
    localparam int unsigned DIV_W       = 32;
    localparam int unsigned SYNC_STAGES = 2;

    logic                 clk = 1'b0;
    logic                 rst_ni = 1'b0;
    logic                 rx_i = 1'b1;
    logic [DIV_W-1:0]     cfg_div_i = 32'd16;
    logic [1:0]           cfg_parity_i = 2'b00;
    logic                 cfg_stop2_i = 1'b0;
    logic [DATA_BITS-1:0] rdata_o;
    logic                 rvalid_o;
    logic                 rready_i = 1'b0;
    logic                 frame_err_o;
    logic                 parity_err_o;
    logic                 overflow_o;
    logic                 busy_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int rise_cyc = -1;
    int n_ferr = 0;
    int n_perr = 0;
    int n_ovf = 0;
    int f0, p0, o0;
    logic rvalid_d = 1'b0;
    logic [7:0] exp_q [$];

    udm_uart_rx_fifo #(
        .DATA_BITS   (DATA_BITS),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .DIV_W       (DIV_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .rx_i         (rx_i),
        .cfg_div_i    (cfg_div_i),
        .cfg_parity_i (cfg_parity_i),
        .cfg_stop2_i  (cfg_stop2_i),
        .rdata_o      (rdata_o),
        .rvalid_o     (rvalid_o),
        .rready_i     (rready_i),
        .frame_err_o  (frame_err_o),
        .parity_err_o (parity_err_o),
        .overflow_o   (overflow_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Count pulse cycles and timestamp the first rvalid rise after arming
    always @(negedge clk) begin
        if (frame_err_o)  n_ferr++;
        if (parity_err_o) n_perr++;
        if (overflow_o)   n_ovf++;
        if (rvalid_o && !rvalid_d && rise_cyc < 0) rise_cyc = cyc;
        rvalid_d = rvalid_o;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic v, input int div);
        rx_i = v;
        step(div);
    endtask

    task automatic send_frame(input logic [7:0] data, input int div, input bit use_par,
                              input logic par_bit, input logic stop_val, input bit two_stop);
        @(posedge clk);
        #1;
        start_cyc = cyc;
        drive_bit(1'b0, div);
        for (int i = 0; i < 8; i++) drive_bit(data[i], div);
        if (use_par) drive_bit(par_bit, div);
        drive_bit(stop_val, div);
        if (two_stop) drive_bit(stop_val, div);
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] e;
        int n;
        n = 0;
        while (!rvalid_o && n < 400) begin
            step(1);
            n++;
        end
        check({tag, "_valid"}, 32'(rvalid_o), 32'd1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        check({tag, "_data"}, 32'(rdata_o), 32'(e));
        rready_i = 1'b1;
        step(1);
        rready_i = 1'b0;
    endtask

    initial begin
        step(3);
        check("rst_rvalid", 32'(rvalid_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        rst_ni = 1'b1;
        step(2);
        check("rst_rdata", 32'(rdata_o), 32'd0);
        check("rst_pulses", {29'd0, frame_err_o, parity_err_o, overflow_o}, 32'd0);

        // Plain 8N1 byte and its output latency
        f0 = n_ferr; p0 = n_perr; o0 = n_ovf;
        rise_cyc = -1;
        send_frame(8'hA5, 16, 0, 1'b0, 1'b1, 0);
        exp_q.push_back(8'hA5);
        check("a5_latency", 32'(rise_cyc - start_cyc), 32'd156);
        pop_check("a5");
        check("a5_no_err", 32'(n_ferr - f0 + n_perr - p0 + n_ovf - o0), 32'd0);

        // Even parity: wrong bit discarded, right bit accepted
        cfg_parity_i = 2'b01;
        send_frame(8'h07, 16, 1, 1'b0, 1'b1, 0);
        step(4);
        check("par_bad_pulse", 32'(n_perr - p0), 32'd1);
        check("par_bad_empty", 32'(rvalid_o), 32'd0);
        send_frame(8'h07, 16, 1, 1'b1, 1'b1, 0);
        exp_q.push_back(8'h07);
        pop_check("par_good");
        check("par_good_pulse", 32'(n_perr - p0), 32'd1);

        // Odd parity with two stop bits
        cfg_parity_i = 2'b10;
        cfg_stop2_i  = 1'b1;
        send_frame(8'h5A, 16, 1, 1'b1, 1'b1, 1);
        exp_q.push_back(8'h5A);
        pop_check("odd2");
        check("odd2_no_err", 32'(n_ferr - f0 + n_perr - p0 - 1), 32'd0);
        cfg_parity_i = 2'b00;
        cfg_stop2_i  = 1'b0;

        // Stop bit low followed by a held-low line, then recovery
        f0 = n_ferr;
        send_frame(8'h55, 16, 0, 1'b0, 1'b0, 0);
        step(100);
        check("brk_ferr", 32'(n_ferr - f0), 32'd1);
        check("brk_busy", 32'(busy_o), 32'd1);
        check("brk_empty", 32'(rvalid_o), 32'd0);
        rx_i = 1'b1;
        step(4);
        check("brk_idle", 32'(busy_o), 32'd0);
        send_frame(8'h3C, 16, 0, 1'b0, 1'b1, 0);
        exp_q.push_back(8'h3C);
        pop_check("brk_3c");

        // Five-cycle start glitch is rejected at the start-bit sample
        f0 = n_ferr; p0 = n_perr;
        step(1);
        rx_i = 1'b0;
        step(3);
        check("gl_busy_on", 32'(busy_o), 32'd1);
        step(2);
        rx_i = 1'b1;
        step(5);
        check("gl_busy_t8", 32'(busy_o), 32'd1);
        step(1);
        check("gl_idle", 32'(busy_o), 32'd0);
        step(20);
        check("gl_nobyte", 32'(rvalid_o), 32'd0);
        check("gl_noerr", 32'(n_ferr - f0 + n_perr - p0), 32'd0);

        // Divider change mid-frame only applies to the next frame; 2 clamps to 4
        fork
            send_frame(8'h96, 16, 0, 1'b0, 1'b1, 0);
            begin
                step(50);
                cfg_div_i = 32'd32;
            end
        join
        exp_q.push_back(8'h96);
        send_frame(8'h69, 32, 0, 1'b0, 1'b1, 0);
        exp_q.push_back(8'h69);
        pop_check("div16");
        pop_check("div32");
        cfg_div_i = 32'd2;
        send_frame(8'hC3, 4, 0, 1'b0, 1'b1, 0);
        exp_q.push_back(8'hC3);
        pop_check("div2");
        cfg_div_i = 32'd16;

        // Fill past capacity with the consumer stalled, then drain in order
        o0 = n_ovf;
        for (int i = 0; i < 17; i++) begin
            send_frame(8'(i), 16, 0, 1'b0, 1'b1, 0);
            if (i < 16) exp_q.push_back(8'(i));
        end
        step(4);
        check("ovf_pulse", 32'(n_ovf - o0), 32'd1);
        check("ovf_head", 32'(rdata_o), 32'd0);
        for (int i = 0; i < 16; i++) pop_check("drain");
        check("drain_empty", 32'(rvalid_o), 32'd0);
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
